sim_sram_log_sink: RTL and testbench



---
 rtl/tlul_pkg.sv | 33 +++
 rtl/sim_sram_log_sink.sv | 185 ++++++++++++++++++
 tb/tb_sim_sram_log_sink.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/tlul_pkg.sv
// Minimal TL-UL channel types used by the sim SRAM log sink.
// Fixed 32-bit address/data, 4-bit byte mask, 8-bit source id.
package tlul_pkg;

  localparam logic [2:0] PutFullData    = 3'd0;
  localparam logic [2:0] PutPartialData = 3'd1;
  localparam logic [2:0] Get            = 3'd4;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/sim_sram_log_sink.sv
// sim_sram_log_sink
// Passive snooper on the simulation-SRAM TL-UL port. Decodes a status
// mailbox word (drives a small test-status FSM) and a console mailbox word
// (bytes buffered in a ready/valid FIFO for the DV environment). Never
// drives TL.
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   tl_h2d_i          snooped request channel
//   tl_d2h_i          snooped response channel (only a_ready used)
//   start_addr_i      sim SRAM base address (quasi-static)
//   log_valid_o/log_data_o/log_ready_i   console FIFO head
//   status_code_o     last accepted status value
//   test_done_o       FSM in PASSED or FAILED
//   test_passed_o     FSM in PASSED
//   write_cnt_o       accepted in-window writes
//   drop_cnt_o        console bytes dropped on a full FIFO (saturating)
//
// state     | meaning
// ----------+----------------------------------------------
// StIdle    | no in-window write seen since reset
// StRunning | test active, status not terminal yet
// StPassed  | PassCode written; status frozen until reset
// StFailed  | FailCode written; status frozen until reset
module sim_sram_log_sink
  import tlul_pkg::*;
#(
  parameter int                 AddrWidth    = 32,
  parameter int                 Width        = 32,
  parameter logic [AddrWidth-1:0] StatusOffset = 32'h0,
  parameter logic [AddrWidth-1:0] LogOffset    = 32'h4,
  parameter int                 LogDepth     = 16,
  parameter logic [15:0]        PassCode     = 16'h900D,
  parameter logic [15:0]        FailCode     = 16'hBAAD
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  tl_h2d_t              tl_h2d_i,
  input  tl_d2h_t              tl_d2h_i,
  input  logic [AddrWidth-1:0] start_addr_i,
  output logic                 log_valid_o,
  output logic [7:0]           log_data_o,
  input  logic                 log_ready_i,
  output logic [15:0]          status_code_o,
  output logic                 test_done_o,
  output logic                 test_passed_o,
  output logic [31:0]          write_cnt_o,
  output logic [15:0]          drop_cnt_o
);

  localparam int AlignBits = $clog2(Width / 8);
  localparam int PtrW      = $clog2(LogDepth);
  localparam int CntW      = PtrW + 1;
  localparam logic [CntW-1:0] FullCount = CntW'(LogDepth);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRunning = 2'd1,
    StPassed  = 2'd2,
    StFailed  = 2'd3
  } state_e;

  state_e state_q;

  // Request decode
  logic                 fire;
  logic                 in_window;
  logic [AddrWidth-1:0] offset;
  logic                 status_addr_hit;
  logic                 log_addr_hit;
  logic                 status_wr;
  logic                 push_req;
  logic [15:0]          wr_code;
  logic                 terminal;

  assign fire = tl_h2d_i.a_valid & tl_d2h_i.a_ready &
                ((tl_h2d_i.a_opcode == PutFullData) |
                 (tl_h2d_i.a_opcode == PutPartialData));

  // Only the lower bound is checked; the window size belongs to the socket.
  assign in_window = (tl_h2d_i.a_address >= start_addr_i);
  assign offset    = tl_h2d_i.a_address - start_addr_i;

  assign status_addr_hit = fire & in_window &
      (offset[AddrWidth-1:AlignBits] == StatusOffset[AddrWidth-1:AlignBits]);
  // Status decode wins if both mailboxes share an address.
  assign log_addr_hit = fire & in_window & ~status_addr_hit &
      (offset[AddrWidth-1:AlignBits] == LogOffset[AddrWidth-1:AlignBits]);

  assign status_wr = status_addr_hit & (tl_h2d_i.a_mask[1:0] == 2'b11);
  assign push_req  = log_addr_hit & tl_h2d_i.a_mask[0];
  assign wr_code   = tl_h2d_i.a_data[15:0];
  assign terminal  = (state_q == StPassed) | (state_q == StFailed);

  // Test-status FSM with registered decodes
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      status_code_o <= '0;
      test_done_o   <= 1'b0;
      test_passed_o <= 1'b0;
    end else if (fire && in_window && !terminal) begin
      if (status_wr && (wr_code == PassCode)) begin
        state_q       <= StPassed;
        test_done_o   <= 1'b1;
        test_passed_o <= 1'b1;
      end else if (status_wr && (wr_code == FailCode)) begin
        state_q       <= StFailed;
        test_done_o   <= 1'b1;
        test_passed_o <= 1'b0;
      end else begin
        state_q <= StRunning;
      end
      if (status_wr) begin
        status_code_o <= wr_code;
      end
    end
  end

  // Console FIFO
  logic [7:0]      mem_q [LogDepth];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            full;
  logic            pop;
  logic            push_ok;
  logic            drop;

  assign full        = (count_q == FullCount);
  assign log_valid_o = (count_q != '0);
  assign log_data_o  = mem_q[rd_ptr_q];
  assign pop         = log_valid_o & log_ready_i;
  // A same-cycle pop frees a slot for the incoming byte.
  assign push_ok     = push_req & (~full | pop);
  assign drop        = push_req & full & ~pop;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < LogDepth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= tl_h2d_i.a_data[7:0];
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      write_cnt_o <= '0;
      drop_cnt_o  <= '0;
    end else begin
      if (fire && in_window) begin
        write_cnt_o <= write_cnt_o + 32'd1;
      end
      if (drop && (drop_cnt_o != 16'hFFFF)) begin
        drop_cnt_o <= drop_cnt_o + 16'd1;
      end
    end
  end

  logic unused_inputs;
  assign unused_inputs = ^{tl_h2d_i.a_param, tl_h2d_i.a_size, tl_h2d_i.a_source,
                           tl_h2d_i.a_mask[3:2], tl_h2d_i.a_data[31:16],
                           tl_h2d_i.d_ready, offset[AlignBits-1:0],
                           tl_d2h_i.d_valid, tl_d2h_i.d_opcode, tl_d2h_i.d_param,
                           tl_d2h_i.d_size, tl_d2h_i.d_source, tl_d2h_i.d_sink,
                           tl_d2h_i.d_data, tl_d2h_i.d_error};

endmodule

// File: tb/tb_sim_sram_log_sink.sv
module tb_sim_sram_log_sink;
  import tlul_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  tl_h2d_t     tl_h2d;
  tl_d2h_t     tl_d2h;
  logic [31:0] start_addr;
  logic        log_valid;
  logic [7:0]  log_data;
  logic        log_ready;
  logic [15:0] status_code;
  logic        test_done;
  logic        test_passed;
  logic [31:0] write_cnt;
  logic [15:0] drop_cnt;

  int checks   = 0;
  int failures = 0;

  sim_sram_log_sink dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .tl_h2d_i      (tl_h2d),
    .tl_d2h_i      (tl_d2h),
    .start_addr_i  (start_addr),
    .log_valid_o   (log_valid),
    .log_data_o    (log_data),
    .log_ready_i   (log_ready),
    .status_code_o (status_code),
    .test_done_o   (test_done),
    .test_passed_o (test_passed),
    .write_cnt_o   (write_cnt),
    .drop_cnt_o    (drop_cnt)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request beat: driven at negedge, sampled by the DUT at the next
  // posedge, then removed; callers check outputs right after.
  task automatic tl_req(input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] mask);
    @(negedge clk_i);
    tl_h2d.a_valid   = 1'b1;
    tl_h2d.a_opcode  = op;
    tl_h2d.a_address = addr;
    tl_h2d.a_data    = data;
    tl_h2d.a_mask    = mask;
    @(posedge clk_i);
    #1;
    tl_h2d.a_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},  {31'd0, log_valid},   32'd0);
    check({tag, "_data"},   {24'd0, log_data},    32'd0);
    check({tag, "_status"}, {16'd0, status_code}, 32'd0);
    check({tag, "_done"},   {31'd0, test_done},   32'd0);
    check({tag, "_passed"}, {31'd0, test_passed}, 32'd0);
    check({tag, "_wcnt"},   write_cnt,            32'd0);
    check({tag, "_drop"},   {16'd0, drop_cnt},    32'd0);
  endtask

  initial begin
    tl_h2d         = '0;
    tl_d2h         = '0;
    tl_d2h.a_ready = 1'b1;
    start_addr     = 32'h3000_0000;
    log_ready      = 1'b1;
    rst_i          = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    check_all_zero("reset");

    // Console bytes with consumer ready: each visible one cycle after its push
    tl_req(PutFullData, 32'h3000_0004, 32'h41, 4'hF);
    check("c41_valid", {31'd0, log_valid}, 32'd1);
    check("c41_data", {24'd0, log_data}, 32'h41);
    tl_req(PutFullData, 32'h3000_0004, 32'h42, 4'hF);
    check("c42_data", {24'd0, log_data}, 32'h42);
    tl_req(PutFullData, 32'h3000_0004, 32'h43, 4'hF);
    check("c43_data", {24'd0, log_data}, 32'h43);
    idle_cycle();
    check("c_empty", {31'd0, log_valid}, 32'd0);
    check("c_wcnt", write_cnt, 32'd3);
    check("c_drop", {16'd0, drop_cnt}, 32'd0);
    check("c_running_done", {31'd0, test_done}, 32'd0);

    // Fill with consumer stalled: 18 writes, 16 kept, 2 dropped
    log_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      tl_req(PutFullData, 32'h3000_0004, 32'h50 + i, 4'hF);
    end
    check("full_valid", {31'd0, log_valid}, 32'd1);
    check("full_head", {24'd0, log_data}, 32'h50);
    check("full_drop", {16'd0, drop_cnt}, 32'd2);
    check("full_wcnt", write_cnt, 32'd21);

    // Full + push + pop in the same cycle: accepted, no drop
    log_ready = 1'b1;
    tl_req(PutFullData, 32'h3000_0004, 32'h99, 4'hF);
    check("pp_drop", {16'd0, drop_cnt}, 32'd2);
    check("pp_head", {24'd0, log_data}, 32'h51);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain%0d_valid", i), {31'd0, log_valid}, 32'd1);
      check($sformatf("drain%0d_data", i), {24'd0, log_data},
            (i < 15) ? (32'h51 + i) : 32'h99);
      idle_cycle();
    end
    check("drain_empty", {31'd0, log_valid}, 32'd0);
    check("drain_wcnt", write_cnt, 32'd22);

    // Status mailbox
    tl_req(PutPartialData, 32'h3000_0000, 32'h1234, 4'b1100);
    check("st_partial", {16'd0, status_code}, 32'd0);
    check("st_partial_wcnt", write_cnt, 32'd23);
    tl_req(PutFullData, 32'h3000_0000, 32'h0001, 4'hF);
    check("st_0001", {16'd0, status_code}, 32'h0001);
    check("st_0001_done", {31'd0, test_done}, 32'd0);
    tl_req(PutFullData, 32'h3000_0000, 32'h900D, 4'hF);
    check("st_pass_code", {16'd0, status_code}, 32'h900D);
    check("st_pass_done", {31'd0, test_done}, 32'd1);
    check("st_pass_passed", {31'd0, test_passed}, 32'd1);
    tl_req(PutFullData, 32'h3000_0000, 32'hBAAD, 4'hF);
    check("st_frozen_code", {16'd0, status_code}, 32'h900D);
    check("st_frozen_passed", {31'd0, test_passed}, 32'd1);
    check("st_frozen_wcnt", write_cnt, 32'd26);

    // Alignment, masks, ignored opcodes and out-of-window addresses
    tl_req(PutFullData, 32'h3000_0005, 32'h61, 4'hF);
    check("unal_valid", {31'd0, log_valid}, 32'd1);
    check("unal_data", {24'd0, log_data}, 32'h61);
    tl_req(PutPartialData, 32'h3000_0004, 32'h62, 4'b1110);
    check("nomask_empty", {31'd0, log_valid}, 32'd0);
    check("nomask_wcnt", write_cnt, 32'd28);
    tl_req(Get, 32'h3000_0004, 32'h63, 4'hF);
    check("get_empty", {31'd0, log_valid}, 32'd0);
    check("get_wcnt", write_cnt, 32'd28);
    tl_req(PutFullData, 32'h2FFF_FFFC, 32'h64, 4'hF);
    check("below_wcnt", write_cnt, 32'd28);
    check("below_empty", {31'd0, log_valid}, 32'd0);
    tl_d2h.a_ready = 1'b0;
    tl_req(PutFullData, 32'h3000_0004, 32'h65, 4'hF);
    tl_d2h.a_ready = 1'b1;
    check("noready_wcnt", write_cnt, 32'd28);
    check("noready_empty", {31'd0, log_valid}, 32'd0);

    // Fail straight from IDLE, buffer bytes, then reset mid-test
    do_reset();
    check_all_zero("reset2");
    tl_req(PutFullData, 32'h3000_0000, 32'hBAAD, 4'hF);
    check("fail_done", {31'd0, test_done}, 32'd1);
    check("fail_passed", {31'd0, test_passed}, 32'd0);
    check("fail_code", {16'd0, status_code}, 32'hBAAD);
    log_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tl_req(PutFullData, 32'h3000_0004, 32'h70 + i, 4'hF);
    end
    check("buf5_valid", {31'd0, log_valid}, 32'd1);
    check("buf5_wcnt", write_cnt, 32'd6);
    do_reset();
    check_all_zero("reset3");
    tl_req(PutFullData, 32'h3000_0004, 32'h77, 4'hF);
    check("post_valid", {31'd0, log_valid}, 32'd1);
    check("post_data", {24'd0, log_data}, 32'h77);
    check("post_wcnt", write_cnt, 32'd1);
    check("post_done", {31'd0, test_done}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
